// File: rtl/alu_operand_stage.sv
// ALU operand stage: selects and forwards the two ALU operands, stalls on in-flight
// forwarding results, and registers the operand pair behind a valid/ready handshake.
module alu_operand_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [1:0]              aluIn1Sel,
    input  logic [1:0]              aluIn2Sel,
    input  logic [4:0]              rs1Addr,
    input  logic [4:0]              rs2Addr,
    input  logic [XLEN-1:0]         regReadData1,
    input  logic [XLEN-1:0]         regReadData2,
    input  logic [XLEN-1:0]         PC,
    input  logic [XLEN-1:0]         imm,
    input  logic [NUM_FWD-1:0]      fwdValid,
    input  logic [NUM_FWD-1:0]      fwdPending,
    input  logic [5*NUM_FWD-1:0]    fwdRd,
    input  logic [XLEN*NUM_FWD-1:0] fwdData,
    input  logic                    flush,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [XLEN-1:0]         aluIn1,
    output logic [XLEN-1:0]         aluIn2,
    output logic [CNT_W-1:0]        stallCount
);

    localparam int unsigned REG_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] fwd1Data, fwd2Data;
    logic            fwd1Hit, fwd2Hit;
    logic            fwd1Pend, fwd2Pend;
    logic [XLEN-1:0] cand1, cand2;
    logic [XLEN-1:0] op1Res, op2Res;
    logic            use1Fwd, use2Fwd;
    logic            hazard;
    logic            capture;

    // Forward match search; scanning downward lets the lowest index win.
    always_comb begin
        fwd1Data = '0;
        fwd2Data = '0;
        fwd1Hit  = 1'b0;
        fwd2Hit  = 1'b0;
        fwd1Pend = 1'b0;
        fwd2Pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwdValid[i] && (fwdRd[i*REG_W +: REG_W] == rs1Addr)) begin
                fwd1Hit  = 1'b1;
                fwd1Data = fwdData[i*XLEN +: XLEN];
                fwd1Pend = fwdPending[i];
            end
            if (fwdValid[i] && (fwdRd[i*REG_W +: REG_W] == rs2Addr)) begin
                fwd2Hit  = 1'b1;
                fwd2Data = fwdData[i*XLEN +: XLEN];
                fwd2Pend = fwdPending[i];
            end
        end
    end

    always_comb begin
        cand1 = '0;
        cand2 = '0;
        case (aluIn1Sel)
            2'b00:   cand1 = regReadData1;
            2'b01:   cand1 = PC;
            default: cand1 = '0;
        endcase
        case (aluIn2Sel)
            2'b00:   cand2 = regReadData2;
            2'b01:   cand2 = imm;
            2'b10:   cand2 = XLEN'(4);
            default: cand2 = '0;
        endcase
    end

    // Register 0 is never forwarded.
    assign use1Fwd = (aluIn1Sel == 2'b00) && (rs1Addr != 5'd0) && fwd1Hit;
    assign use2Fwd = (aluIn2Sel == 2'b00) && (rs2Addr != 5'd0) && fwd2Hit;
    assign op1Res  = use1Fwd ? fwd1Data : cand1;
    assign op2Res  = use2Fwd ? fwd2Data : cand2;

    assign hazard  = (use1Fwd && fwd1Pend) || (use2Fwd && fwd2Pend);
    assign inReady = (!outValid || outReady) && !hazard && !flush;
    assign capture = inValid && inReady;

    // Output pipeline register; flush beats capture, capture beats drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            aluIn1   <= '0;
            aluIn2   <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (capture) begin
            outValid <= 1'b1;
            aluIn1   <= op1Res;
            aluIn2   <= op2Res;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCount <= '0;
        end else if (inValid && hazard && !flush && (stallCount != CNT_MAX)) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_FWD, default 2, number of forwarding sources; index 0 is highest priority.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port inValid / inReady  in / out  1  upstream handshake.
REQ-007 SHALL have port aluIn1Sel  in  2  operand-1 source: 00 regReadData1, 01 PC, 10 zero, 11 zero.
REQ-008 SHALL have port aluIn2Sel  in  2  operand-2 source: 00 regReadData2, 01 imm, 10 constant 4, 11 zero.
REQ-009 SHALL have ports rs1Addr, rs2Addr  in  5 each  source register numbers.
REQ-010 SHALL have ports regReadData1, regReadData2, PC, imm  in  XLEN each  candidate operands.
REQ-011 SHALL have ports fwdValid, fwdPending  in  NUM_FWD  per-source result valid / result not yet available (load in flight).
REQ-012 SHALL have ports fwdRd  in  5*NUM_FWD  and fwdData  in  XLEN*NUM_FWD  per-source destination and data, source i in slice i.
REQ-013 SHALL have port flush  in  1  discard held operands.
REQ-014 SHALL have ports outValid / outReady  out / in  1  downstream handshake.
REQ-015 SHALL have ports aluIn1, aluIn2  out  XLEN each  registered operands.
REQ-016 SHALL have port stallCount  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-017 SHALL resolve operand 1 as follows. When aluIn1Sel=00, rs1Addr!=0 and some source i has fwdValid[i] && fwdRd[i]==rs1Addr, SHALL use fwdData of the lowest such i. Otherwise SHALL use the selected candidate per REQ-007. Operand 2 SHALL be resolved identically using aluIn2Sel=00 and rs2Addr.
REQ-018 SHALL never forward for register 0; operand SHALL be regReadData for rs=0 with select 00.
REQ-019 SHALL assert hazard (combinational) when a register-selected operand matches source i via REQ-017 and fwdPending[i]=1; the lowest matching i decides.
REQ-020 SHALL drive inReady = (!outValid || outReady) && !hazard && !flush.
REQ-021 SHALL capture resolved operands into aluIn1/aluIn2 and set outValid=1 on the cycle after inValid && inReady; latency exactly 1 cycle.
REQ-022 SHALL hold aluIn1, aluIn2, outValid stable while outValid && !outReady.
REQ-023 SHALL clear outValid on outValid && outReady with no new capture; simultaneous drain and capture SHALL keep outValid=1 with new data (full throughput, one transfer per cycle).
REQ-024 SHALL, on flush, clear outValid next edge and accept no input that cycle; flush SHALL take priority over capture and hold; operand registers may retain stale data.
REQ-025 SHALL increment stallCount each cycle with inValid && hazard && !flush, saturating at 2^CNT_W-1, with no wrap.
REQ-026 SHALL produce all arithmetic modulo XLEN bits; the constant 4 SHALL be zero-extended to XLEN.

Reset
REQ-027 SHALL, while rst_n=0, force outValid=0, aluIn1=0, aluIn2=0, stallCount=0 immediately, independent of clk.
REQ-028 SHALL discard any held operand pair when reset is asserted mid-transfer; first capture SHALL occur no earlier than first rising edge after rst_n deasserts.

Verification
REQ-029 SHALL cover: aluIn1Sel=01, PC=0x0000_1000, aluIn2Sel=10, inValid=1, outReady=1 -> next cycle outValid=1, aluIn1=0x1000, aluIn2=0x4.
REQ-030 SHALL cover: rs1Addr=5, sel 00, fwdValid=11, fwdRd={5,5}, fwdData[0]=0xAAAA, fwdData[1]=0xBBBB -> aluIn1=0xAAAA; with rs1Addr=0 -> aluIn1=regReadData1.
REQ-031 SHALL cover: fwdPending[0]=1 matching rs2Addr=7, inValid held 3 cycles -> inReady=0 for 3 cycles, stallCount=3, outValid stays 0; on pending clear, capture with fwdData[0] next edge.
REQ-032 SHALL cover: outValid=1, outReady=0 for 4 cycles with changing inputs -> aluIn1/aluIn2 unchanged, inReady=0; outReady=1 with inValid=1 -> back-to-back transfer, outValid stays 1.
REQ-033 SHALL cover: flush=1 with inValid=1 and outValid=1 -> next cycle outValid=0, no capture; stallCount preset near 2^CNT_W-1 under continued hazard -> saturates.
REQ-034 SHALL cover: rst_n pulled low between clock edges while outValid=1 -> outValid, aluIn1, aluIn2, stallCount read 0 before next edge.
